// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: full 2W-bit signed/unsigned product in W steps.
// Holds the pipeline via a combinational stall until the product is valid.
module seq_multiplier #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           u,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           stall,
  output logic [2*W-1:0] z
);

  localparam int unsigned CW = $clog2(W + 2);
  localparam logic [CW-1:0] S_LAST = CW'(W);
  localparam logic [CW-1:0] S_DONE = CW'(W + 1);

  logic [CW-1:0]  s_q, s_d;
  logic [2*W-1:0] p_q, p_d;
  logic [W-1:0]   x_q, x_d;
  logic           u_q, u_d;

  logic [W-1:0] m;
  logic [W:0]   hi, mm, sum;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= '0;
      p_q <= '0;
      x_q <= '0;
      u_q <= 1'b0;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
      x_q <= x_d;
      u_q <= u_d;
    end
  end

  // One shift-add step; the last step subtracts to weight the multiplier sign bit
  always_comb begin
    m   = p_q[0] ? x_q : '0;
    hi  = u_q ? {p_q[2*W-1], p_q[2*W-1:W]} : {1'b0, p_q[2*W-1:W]};
    mm  = u_q ? {m[W-1], m} : {1'b0, m};
    sum = (u_q && (s_q == S_LAST)) ? (hi - mm) : (hi + mm);
  end

  // Next-state: counter, load on S=0, step for 1..W, hold when saturated or idle
  always_comb begin
    s_d = s_q;
    p_d = p_q;
    x_d = x_q;
    u_d = u_q;
    if (!run) begin
      s_d = '0;
    end else begin
      if (s_q != S_DONE) s_d = s_q + CW'(1);
      if (s_q == '0) begin
        x_d = x;
        u_d = u;
        p_d = {W'(0), y};
      end else if (s_q != S_DONE) begin
        p_d = {sum, p_q[W-1:1]};
      end
    end
  end

  assign stall = run & (s_q != S_DONE);
  assign z     = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized scoreboard bench for seq_multiplier against an arithmetic product model.
module tb_seq_multiplier;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           run;
  logic           u;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           stall;
  logic [2*W-1:0] z;

  int n_chk  = 0;
  int n_fail = 0;
  int completions = 0;

  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] held_z;
  int  stall_cnt = 0;
  bit  done = 0;

  seq_multiplier #(.W(W)) dut (
    .clk(clk), .rst(rst), .run(run), .u(u), .x(x), .y(y), .stall(stall), .z(z)
  );

  always #5 clk = ~clk;

  // Reference: exact product of the extended operands, modulo 2^(2W)
  function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic signed [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles of a request and scores the product when stall drops
  always @(negedge clk) begin
    if (!rst || !run) begin
      stall_cnt = 0;
      done = 0;
    end else if (!done) begin
      if (stall) begin
        stall_cnt++;
      end else begin
        done = 1;
        check("stall_cycles", 64'(stall_cnt), 64'(W + 1));
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: z=%h with empty scoreboard", z);
          held_z = z;
        end else begin
          held_z = sb.pop_front();
          check("product", z, held_z);
        end
        completions++;
      end
    end else begin
      check("hold_stall", 64'(stall), 64'(0));
      check("hold_z", z, held_z);
    end
  end

  task automatic wait_done(input int start);
    for (int i = 0; i < 3 * W && completions == start; i++) @(posedge clk);
    if (completions == start) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: no result after %0d cycles, stall=%b", 3 * W, stall);
    end
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full request: push expected, raise run, wait, optionally hold run extra cycles
  task automatic do_mul(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int extra, input bit wiggle);
    int start;
    start = completions;
    sb.push_back(ref_mul(s, a, b));
    u = s; x = a; y = b;
    run = 1'b1;
    if (wiggle) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      x = $urandom; y = $urandom; u = ~s;
    end
    wait_done(start);
    repeat (extra) @(posedge clk);
    end_req();
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; u = 1'b0; x = '0; y = '0;
    #1;
    check("reset_z", z, '0);
    check("reset_stall", 64'(stall), 64'(0));
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    do_mul(1'b0, 32'd3, 32'd5, 0, 0);
    do_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    do_mul(1'b1, 32'hFFFFFFFD, 32'd5, 0, 0);
    do_mul(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    do_mul(1'b1, 32'h80000000, 32'h80000000, 0, 0);
    do_mul(1'b1, 32'h80000000, 32'd1, 0, 0);
    do_mul(1'b0, 32'h80000000, 32'h80000000, 0, 0);
    do_mul(1'b1, 32'h7FFFFFFF, 32'h80000000, 0, 0);
    do_mul(1'b0, 32'h12345678, 32'h9ABCDEF0, 10, 1);
    do_mul(1'b1, 32'hDEADBEEF, 32'h0000FFFF, 10, 1);

    // Abort at S=10, then a clean 7*6
    u = 1'b0; x = 32'hCAFEF00D; y = 32'h0BADBEEF;
    run = 1'b1;
    repeat (10) @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    do_mul(1'b0, 32'd7, 32'd6, 0, 0);

    // Reset at S=20 with run held: immediate clear, then a fresh product
    u = 1'b1; x = 32'hFFFF0001; y = 32'h00012345;
    run = 1'b1;
    repeat (20) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midreset_z", z, '0);
    check("midreset_stall", 64'(stall), 64'(1));
    @(posedge clk); #1;
    begin
      int start;
      start = completions;
      sb.push_back(ref_mul(1'b1, 32'hFFFF0001, 32'h00012345));
      rst = 1'b1;
      wait_done(start);
    end
    end_req();

    // Randomized requests, biased toward boundary operand values
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = '0;
        default: ;
      endcase
      do_mul(1'($urandom_range(0, 1)), a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential shift-add integer multiplier for the RISC5 execute stage; the counterpart of the sequential divider on the same processor interface (run/u/stall).
- Computes the full 2W-bit product of two W-bit operands, signed or unsigned, in W steps.
- Holds the pipeline through `stall` until the product is valid.

Parameters:
- W, 32, operand width. Product width is 2W. Counter width is clog2(W+2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  multiply request; held high by the core until `stall` is low.
- u  input  1  1 = signed (two's complement) operands, 0 = unsigned.
- x  input  W  multiplicand.
- y  input  W  multiplier.
- stall  output  1  high while a requested product is not yet valid.
- z  output  2W  product.

Behaviour:
- State: step counter S; product/shift register P (2W bits); latched multiplicand X (W bits); latched mode U (1 bit).
- Reset (rst=0, asynchronous): S=0, P=0, X=0, U=0. Outputs: z=0; stall=0 whenever run=0.
- stall is combinational: run & (S != W+1).
- Counter:
  - run=0: S<=0 at the next edge.
  - run=1 and S<W+1: S<=S+1.
  - run=1 and S=W+1: S holds (saturates). stall stays low for as long as run remains high.
- Load (edge with run=1, S=0): X<=x, U<=u, P<={W'b0, y}. After this edge, changes on x, y and u do not affect the result.
- Step (edge with run=1, 1<=S<=W):
  - m = P[0] ? X : 0.
  - hi = ext(P[2W-1:W]), mm = ext(m), where ext is a (W+1)-bit sign-extension if U=1 and a zero-extension if U=0.
  - sum = (U=1 and S=W) ? hi - mm : hi + mm. Computed in W+1 bits, modulo 2^(W+1).
  - P<={sum[W:0], P[W-1:1]}.
  - The final-step subtraction applies the -2^(W-1) weight of the multiplier's sign bit.
- Hold: with S=W+1 or run=0 (other than the load edge), P is unchanged.
- z = P at all times. z is defined as the product only while run=1 and S=W+1.
- Latency:
  - stall is high for W+1 cycles: S=0 through S=W.
  - z is valid in the (W+2)-th cycle of the request, when S=W+1 and stall=0.
- Back-to-back requests: the core drops run for at least one cycle between requests, which returns S to 0. If run is not dropped, no new multiply starts.
- Abort: if run falls mid-operation, S=0 at the next edge. The partial P is retained but meaningless. The next request reloads cleanly.
- Reset mid-operation: all state clears immediately. If run is still high, stall is high, and a fresh load occurs on the first edge after rst returns high.
- Arithmetic is exact modulo 2^(2W). There are no overflow conditions and no exceptions.

Test Plan:
- Unsigned small: u=0, x=3, y=5, run held → stall high for exactly 33 cycles, then z=0x000000000000000F with stall=0.
- Unsigned max: u=0, x=y=0xFFFFFFFF → z=0xFFFFFFFE00000001.
- Signed mixed and negative: u=1, x=0xFFFFFFFD (-3), y=5 → z=0xFFFFFFFFFFFFFFF1. Separately, u=1, x=y=0xFFFFFFFF → z=0x0000000000000001.
- Signed extreme: u=1, x=y=0x80000000 → z=0x4000000000000000. Separately, u=1, x=0x80000000, y=1 → z=0xFFFFFFFF80000000.
- Operand stability and saturation:
  - Change x and y one cycle after the load edge; z must still equal the product of the load-time values.
  - Keep run high for 10 extra cycles after completion; stall must stay 0 and z must be unchanged.
- Abort and reset:
  - Drop run at S=10, then issue a new request 7*6; expect z=42 after 33 stall cycles.
  - Assert rst at S=20 with run high; expect S=0, z=0 and stall=1 immediately, then a correct product 33 cycles after rst is released.
